lsu_mem_ctrl: RTL and testbench
===============================

# lsu_mem_ctrl

Load/store sequencer in front of the single-port data memory (`DataMemory`). It is the only master driving that memory. It accepts one CPU load or store per handshake and performs RV32 byte, halfword and word accesses. It detects misalignment and performs read-modify-write for sub-word stores, because the memory writes whole words only. The memory read is registered, with one-cycle latency, and the controller sequences around that.

## Interface
Parameters:
- A_WIDTH, 32, width of `req_addr` and `mem_A`. The data width is fixed at 32.

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in S_IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads only: zero-extend instead of sign-extend
- req_addr  in  A_WIDTH  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle completion pulse; no backpressure
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal size; valid with rsp_valid
- mem_A  out  A_WIDTH  word index = req_addr >> 2, zero-filled
- mem_WD  out  32  write word
- mem_WE  out  1  write enable; decoded from registered state only
- mem_RD  in  32  registered memory read data, valid the cycle after mem_A is presented

## Operation
- Handshake:
  - A request is accepted on a rising edge with req_valid & req_ready.
  - All request fields are latched at that edge.
  - Inputs are ignored when not in S_IDLE.
- Error check at accept time:
  - An error is size 11, or half with addr[0]=1, or word with addr[1:0]≠0.
  - On error the next state is S_RESP with rsp_err=1.
  - mem_WE is never asserted for an erroneous request.
- Byte lanes are little-endian: byte k = addr[1:0] occupies bits 8k+7:8k. A halfword uses lanes addr[1]*2 and addr[1]*2+1.
- States:
  - S_IDLE: req_ready=1. On accept:
    - error → S_RESP
    - load → S_RD
    - word store → S_WR, with wbuf=req_wdata
    - sub-word store → S_RD
  - S_RD: drive mem_A, mem_WE=0. Next state is S_RDW.
  - S_RDW: mem_RD is valid.
    - Load: extract the lane(s), sign- or zero-extend, and register the result into rsp_rdata. Next state is S_RESP.
    - Sub-word store: merge req_wdata[7:0] or [15:0] into mem_RD at the target lanes to form wbuf. Next state is S_WR.
  - S_WR: drive mem_A, mem_WD=wbuf, mem_WE=1. Next state is S_RESP.
  - S_RESP: rsp_valid=1 for exactly one cycle. Next state is S_IDLE.
- rsp_rdata and rsp_err hold their values until the next S_RESP overwrites them. They are cleared on reset.
- mem_A and mem_WD hold their last values outside S_RD/S_WR. Only mem_WE qualifies them.

## Timing
- Reset values:
  - State S_IDLE; req_ready=1 once RST is low.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - mem_A=0, mem_WD=0, mem_WE=0.
- Latency: count cycles from the accept edge to the cycle in which rsp_valid is high.
  - Load: 3
  - Word store: 2
  - Sub-word store: 4
  - Error: 1
- Throughput: the next request can be accepted in the cycle after the rsp_valid cycle. req_ready is low from the accept edge through S_RESP.
- mem_WE is high for exactly one cycle per successful store and never during a load.
- Reset mid-operation:
  - The transaction is aborted and no response is issued.
  - If RST is asserted during S_WR, mem_WE drops asynchronously with RST. Whether that write lands is undefined.
  - A sub-word store aborted before S_WR leaves memory unchanged.

## Structure
- Shared package `lsu_pkg`:
  - `size_e` enum: BYTE, HALF, WORD, ILLEGAL.
  - `lsu_state_e` enum: S_IDLE, S_RD, S_RDW, S_WR, S_RESP.
  - Function for the misalignment check.
- Sub-module `lsu_lane_align`, purely combinational:
  - Load extract/extend: mem_RD, size, unsigned, addr[1:0] → rdata.
  - Store merge: old word, wdata, size, addr[1:0] → new word.
- The top level holds the FSM, the request latch and the output registers.

## Test plan
Setup: preload word index 1 (bytes 4–7) = 0x8081_F2A4.

- **Byte loads:** LB at addr 5 → rsp_rdata 0xFFFF_FFF2, rsp_err 0, rsp_valid 3 cycles after accept. LBU at addr 5 → 0x0000_00F2. LHU at addr 6 → 0x0000_8081.
- **Byte store:** SB at addr 6 with wdata 0x0000_0055 → mem_A=1, mem_WE high for exactly one cycle with mem_WD 0x8055_F2A4. rsp_valid 4 cycles after accept. A following LW at addr 4 → 0x8055_F2A4.
- **Word store:** SW at addr 8 with 0xDEAD_BEEF → mem_A=2, mem_WD=0xDEAD_BEEF, rsp_valid 2 cycles after accept. A following LW at addr 8 → 0xDEAD_BEEF.
- **Misalignment:**
  - LH at addr 3 → rsp_err=1 and rsp_rdata=0, 1 cycle after accept.
  - SW at addr 6 → rsp_err=1, mem_WE never high, word 1 unchanged.
  - req_size 11 → rsp_err=1.
- **Reset during write:** assert RST during S_WR of an SW. mem_WE falls in the same cycle and rsp_valid is never asserted. After release, req_ready=1 and all outputs are at their reset values.
- **Back-to-back:** hold req_valid high over two queued loads. req_ready is low throughout the busy period, and the second request is accepted in the cycle after the first rsp_valid. Each load produces exactly one rsp_valid pulse.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and access check for the load/store sequencer
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RDW,
    S_WR,
    S_RESP
  } lsu_state_e;

  // Illegal size is folded in so the top needs a single error term.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
    logic bad;
    case (size)
      BYTE:    bad = 1'b0;
      HALF:    bad = off[0];
      WORD:    bad = |off;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - little-endian lane extract/extend for loads and merge for sub-word stores
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rd,
  input  size_e       size,
  input  logic        is_unsigned,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [4:0]  bit_off;

  always_comb begin
    bit_off = {off, 3'b000};
    rd_byte = mem_rd[bit_off +: 8];
    rd_half = off[1] ? mem_rd[31:16] : mem_rd[15:0];

    case (size)
      BYTE:    rdata = {{24{~is_unsigned & rd_byte[7]}}, rd_byte};
      HALF:    rdata = {{16{~is_unsigned & rd_half[15]}}, rd_half};
      default: rdata = mem_rd;
    endcase

    merged = mem_rd;
    case (size)
      BYTE: merged[bit_off +: 8] = wdata[7:0];
      HALF: begin
        if (off[1]) merged[31:16] = wdata[15:0];
        else        merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store sequencer driving a single-port word memory with registered reads
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int A_WIDTH = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [1:0]         req_size,
  input  logic               req_unsigned,
  input  logic [A_WIDTH-1:0] req_addr,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  output logic [A_WIDTH-1:0] mem_A,
  output logic [31:0]        mem_WD,
  output logic               mem_WE,
  input  logic [31:0]        mem_RD
);

  lsu_state_e  state, state_nxt;
  logic        we_q;
  size_e       size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic [31:0] load_data;
  logic [31:0] merged;
  size_e       req_size_e;
  logic        req_err;

  assign req_size_e = size_e'(req_size);
  assign req_err    = is_misaligned(req_size_e, req_addr[1:0]);

  lsu_lane_align u_align (
    .mem_rd      (mem_RD),
    .size        (size_q),
    .is_unsigned (uns_q),
    .off         (off_q),
    .wdata       (wdata_q),
    .rdata       (load_data),
    .merged      (merged)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Handshake and write strobe decode from the state register only, so mem_WE drops with RST.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_WE    = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                          state_nxt = S_RESP;
          else if (req_we && req_size_e == WORD) state_nxt = S_WR;
          else                                  state_nxt = S_RD;
        end
      end
      S_RD:   state_nxt = S_RDW;
      S_RDW:  state_nxt = we_q ? S_WR : S_RESP;
      S_WR: begin
        mem_WE    = 1'b1;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Response registers only change on the edge entering S_RESP; memory address/data only for good requests.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      we_q      <= 1'b0;
      size_q    <= BYTE;
      uns_q     <= 1'b0;
      off_q     <= 2'b00;
      wdata_q   <= '0;
      mem_A     <= '0;
      mem_WD    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size_e;
            uns_q   <= req_unsigned;
            off_q   <= req_addr[1:0];
            wdata_q <= req_wdata;
            if (req_err) begin
              rsp_rdata <= '0;
              rsp_err   <= 1'b1;
            end else begin
              mem_A <= req_addr >> 2;
              if (req_we && req_size_e == WORD) mem_WD <= req_wdata;
            end
          end
        end
        S_RDW: begin
          if (we_q) begin
            mem_WD <= merged;
          end else begin
            rsp_rdata <= load_data;
            rsp_err   <= 1'b0;
          end
        end
        S_WR: begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - scoreboard bench for lsu_mem_ctrl with a registered-read memory model
module tb_lsu_mem_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_A, mem_WD, mem_RD;
  logic        mem_WE;

  lsu_mem_ctrl #(.A_WIDTH(32)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE),
    .mem_RD(mem_RD)
  );

  always #5 CLK = ~CLK;

  logic [31:0] mem [0:15];
  always @(posedge CLK) begin
    mem_RD <= mem[mem_A[3:0]];
    if (mem_WE) mem[mem_A[3:0]] <= mem_WD;
  end

  int cyc = 0;
  always @(posedge CLK) cyc = cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          t0;
  } exp_t;
  exp_t sb[$];

  int n_pass = 0;
  int n_total = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  int          we_cnt = 0;
  logic [31:0] last_a, last_wd;
  exp_t        e;

  always @(negedge CLK) begin
    if (mem_WE) begin
      we_cnt++;
      last_a  = mem_A;
      last_wd = mem_WD;
    end
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        check("rsp_latency", cyc - e.t0, e.lat);
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] xr, input logic xe, input int xl,
                       input bit push, output int busy);
    exp_t n;
    @(negedge CLK);
    req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    busy = 0;
    while (!req_ready && busy < 50) begin
      busy++;
      @(negedge CLK);
    end
    if (!req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      return;
    end
    if (push) begin
      n.rdata = xr; n.err = xe; n.lat = xl; n.t0 = cyc;
      sb.push_back(n);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic drop_valid();
    @(negedge CLK);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(negedge CLK);
      k++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
  endtask

  task automatic run(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] xr, input logic xe, input int xl);
    int b;
    issue(we, sz, uns, addr, wd, xr, xe, xl, 1'b1, b);
    drop_valid();
    drain();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    check({tag, "_mem_A"}, mem_A, 32'd0);
    check({tag, "_mem_WD"}, mem_WD, 32'd0);
    check({tag, "_mem_WE"}, {31'd0, mem_WE}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w0;
    int busy;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    mem[1] = 32'h8081_F2A4;
    mem_RD = 32'd0;
    RST = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    #1;
    check_reset_outputs("reset");

    run(1'b0, 2'b00, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFF2, 1'b0, 3);
    run(1'b0, 2'b00, 1'b1, 32'd5, 32'd0, 32'h0000_00F2, 1'b0, 3);
    run(1'b0, 2'b01, 1'b1, 32'd6, 32'd0, 32'h0000_8081, 1'b0, 3);
    run(1'b0, 2'b01, 1'b0, 32'd4, 32'd0, 32'hFFFF_F2A4, 1'b0, 3);

    w0 = we_cnt;
    run(1'b1, 2'b00, 1'b0, 32'd6, 32'h0000_0055, 32'd0, 1'b0, 4);
    check("sb_we_pulses", we_cnt - w0, 32'd1);
    check("sb_mem_A", last_a, 32'd1);
    check("sb_mem_WD", last_wd, 32'h8055_F2A4);
    run(1'b0, 2'b10, 1'b0, 32'd4, 32'd0, 32'h8055_F2A4, 1'b0, 3);

    w0 = we_cnt;
    run(1'b1, 2'b10, 1'b0, 32'd8, 32'hDEAD_BEEF, 32'd0, 1'b0, 2);
    check("sw_we_pulses", we_cnt - w0, 32'd1);
    check("sw_mem_A", last_a, 32'd2);
    check("sw_mem_WD", last_wd, 32'hDEAD_BEEF);
    run(1'b0, 2'b10, 1'b0, 32'd8, 32'd0, 32'hDEAD_BEEF, 1'b0, 3);

    run(1'b0, 2'b01, 1'b0, 32'd3, 32'd0, 32'd0, 1'b1, 1);
    w0 = we_cnt;
    run(1'b1, 2'b10, 1'b0, 32'd6, 32'h1234_5678, 32'd0, 1'b1, 1);
    check("err_store_we_pulses", we_cnt - w0, 32'd0);
    run(1'b0, 2'b10, 1'b0, 32'd4, 32'd0, 32'h8055_F2A4, 1'b0, 3);
    run(1'b0, 2'b11, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1);

    issue(1'b0, 2'b10, 1'b0, 32'd8, 32'd0, 32'hDEAD_BEEF, 1'b0, 3, 1'b1, busy);
    issue(1'b0, 2'b00, 1'b0, 32'd11, 32'd0, 32'hFFFF_FFDE, 1'b0, 3, 1'b1, busy);
    check("b2b_busy_cycles", busy, 32'd3);
    drop_valid();
    drain();

    issue(1'b1, 2'b10, 1'b0, 32'd12, 32'h1122_3344, 32'd0, 1'b0, 2, 1'b0, busy);
    check("rst_we_in_wr", {31'd0, mem_WE}, 32'd1);
    #2;
    RST = 1'b1;
    req_valid = 1'b0;
    #1;
    check("rst_we_drop", {31'd0, mem_WE}, 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
    check_reset_outputs("post_rst");
    repeat (4) @(negedge CLK);

    run(1'b0, 2'b00, 1'b1, 32'd8, 32'd0, 32'h0000_00EF, 1'b0, 3);

    repeat (3) @(negedge CLK);
    check("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
